// File: rtl/onehot_enc_pkg.sv
// Shared types and helpers for the one-hot to index encoder.
// The helpers take the widest supported word; callers zero-extend
// their narrower input and truncate the returned index.
package onehot_enc_pkg;

    localparam int MAX_W = 8;
    localparam int MAX_N = 1 << MAX_W;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_ZERO  = 2'd1,
        ERR_MULTI = 2'd2
    } err_t;

    // ZERO when no bit is set, MULTI when more than one is set.
    function automatic err_t classify(input logic [MAX_N-1:0] word);
        logic seen;
        logic multi;
        err_t result;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < MAX_N; i++) begin
            if (word[i]) begin
                if (seen) begin
                    multi = 1'b1;
                end
                seen = 1'b1;
            end
        end
        if (!seen) begin
            result = ERR_ZERO;
        end else if (multi) begin
            result = ERR_MULTI;
        end else begin
            result = ERR_NONE;
        end
        return result;
    endfunction

    // Index of the lowest set bit; 0 for an all-zero word.
    function automatic logic [MAX_W-1:0] lsb_index(input logic [MAX_N-1:0] word);
        logic [MAX_W-1:0] idx;
        idx = '0;
        for (int i = MAX_N - 1; i >= 0; i--) begin
            if (word[i]) begin
                idx = MAX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/onehot_enc_stage.sv
// Generic valid/ready pipeline register. Accepts a new word whenever it is
// empty or its current word leaves in the same cycle, so a full pipeline
// still moves one word per clock.
module onehot_enc_stage #(
    parameter int DW = 8
) (
    input  logic          CLK,
    input  logic          RESET_n,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [DW-1:0] up_data,
    output logic          dn_valid,
    input  logic          dn_ready,
    output logic [DW-1:0] dn_data
);

    logic load;

    assign up_ready = !dn_valid || dn_ready;
    assign load     = up_valid && up_ready;

    // Hold the word until downstream takes it; data only changes on a load.
    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            dn_valid <= 1'b0;
            dn_data  <= '0;
        end else begin
            if (load) begin
                dn_valid <= 1'b1;
                dn_data  <= up_data;
            end else if (dn_ready) begin
                dn_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/onehot_encoder.sv
// One-hot to bit-index encoder, the inverse of the one-hot decoder in the
// loopback path. Two register stages: S1 holds the raw word and its error
// class, S2 holds the encoded index and error class. Errored words are either
// forwarded with SOURCE_ERR set or silently dropped before S2 (ERR_DROP=1);
// either way they are counted at the sink in a saturating counter.
module onehot_encoder
    import onehot_enc_pkg::*;
#(
    parameter int W        = 4,
    parameter int CW       = 8,
    parameter int ERR_DROP = 0
) (
    input  logic              CLK,
    input  logic              RESET_n,
    input  logic              SINK_VALID,
    output logic              SINK_READY,
    input  logic [(1<<W)-1:0] SINK_DATA,
    output logic              SOURCE_VALID,
    input  logic              SOURCE_READY,
    output logic [W-1:0]      SOURCE_DATA,
    output err_t              SOURCE_ERR,
    input  logic              ERR_CLR,
    output logic [CW-1:0]     ERR_COUNT
);

    localparam int N = 1 << W;

    err_t           sink_err;
    logic           s1_up_ready;
    logic           s1_valid;
    logic           s1_ready;
    logic [N+1:0]   s1_data;
    logic [N-1:0]   s1_word;
    err_t           s1_err;
    logic [W-1:0]   s1_idx;
    logic           s1_drop;
    logic           s2_up_valid;
    logic           s2_up_ready;
    logic [W+1:0]   s2_data;
    logic           err_accept;

    assign sink_err   = classify(MAX_N'(SINK_DATA));
    assign SINK_READY = RESET_n && s1_up_ready;
    assign err_accept = SINK_VALID && SINK_READY && (sink_err != ERR_NONE);

    onehot_enc_stage #(
        .DW (N + 2)
    ) u_s1 (
        .CLK      (CLK),
        .RESET_n  (RESET_n),
        .up_valid (SINK_VALID),
        .up_ready (s1_up_ready),
        .up_data  ({sink_err, SINK_DATA}),
        .dn_valid (s1_valid),
        .dn_ready (s1_ready),
        .dn_data  (s1_data)
    );

    assign s1_word = s1_data[N-1:0];
    assign s1_err  = err_t'(s1_data[N+1:N]);
    assign s1_idx  = W'(lsb_index(MAX_N'(s1_word)));

    // In drop mode an errored word leaves S1 without entering S2, so it
    // must not wait on S2 having room.
    assign s1_drop     = (ERR_DROP != 0) && (s1_err != ERR_NONE);
    assign s2_up_valid = s1_valid && !s1_drop;
    assign s1_ready    = s2_up_ready || s1_drop;

    onehot_enc_stage #(
        .DW (W + 2)
    ) u_s2 (
        .CLK      (CLK),
        .RESET_n  (RESET_n),
        .up_valid (s2_up_valid),
        .up_ready (s2_up_ready),
        .up_data  ({s1_err, s1_idx}),
        .dn_valid (SOURCE_VALID),
        .dn_ready (SOURCE_READY),
        .dn_data  (s2_data)
    );

    assign SOURCE_DATA = s2_data[W-1:0];
    assign SOURCE_ERR  = err_t'(s2_data[W+1:W]);

    // Saturating error count; a clear that coincides with an errored
    // accept restarts the count at one so that word is not lost.
    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            ERR_COUNT <= '0;
        end else if (ERR_CLR) begin
            ERR_COUNT <= err_accept ? CW'(1) : '0;
        end else if (err_accept && (ERR_COUNT != {CW{1'b1}})) begin
            ERR_COUNT <= ERR_COUNT + 1'b1;
        end
    end

endmodule

// File: tb/tb_onehot_encoder.sv
// Self-checking bench for onehot_encoder: a forwarding instance, a dropping
// instance and a 2-bit-counter instance share one stimulus stream. Accepted
// words are pushed to per-instance scoreboards and compared on output.
module tb_onehot_encoder;
    import onehot_enc_pkg::*;

    typedef struct {
        logic [15:0] din;
        logic [3:0]  idx;
        err_t        err;
        int          acc_n;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sink_valid;
    logic [15:0] sink_data;
    logic        src_ready;
    logic        err_clr;

    logic        m_sink_ready, m_src_valid;
    logic [3:0]  m_src_data;
    err_t        m_src_err;
    logic [7:0]  m_cnt;

    logic        d_sink_ready, d_src_valid;
    logic [3:0]  d_src_data;
    err_t        d_src_err;
    logic [7:0]  d_cnt;

    logic        s_sink_ready, s_src_valid;
    logic [3:0]  s_src_data;
    err_t        s_src_err;
    logic [1:0]  s_cnt;

    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   retries = 0;
    bit   lat_chk = 1'b1;
    ent_t q[$];
    ent_t qd[$];
    ent_t e;
    ent_t ed;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    onehot_encoder #(.W(4), .CW(8), .ERR_DROP(0)) u_main (
        .CLK(clk), .RESET_n(rst_n), .SINK_VALID(sink_valid), .SINK_READY(m_sink_ready),
        .SINK_DATA(sink_data), .SOURCE_VALID(m_src_valid), .SOURCE_READY(src_ready),
        .SOURCE_DATA(m_src_data), .SOURCE_ERR(m_src_err), .ERR_CLR(err_clr), .ERR_COUNT(m_cnt));

    onehot_encoder #(.W(4), .CW(8), .ERR_DROP(1)) u_drop (
        .CLK(clk), .RESET_n(rst_n), .SINK_VALID(sink_valid), .SINK_READY(d_sink_ready),
        .SINK_DATA(sink_data), .SOURCE_VALID(d_src_valid), .SOURCE_READY(src_ready),
        .SOURCE_DATA(d_src_data), .SOURCE_ERR(d_src_err), .ERR_CLR(err_clr), .ERR_COUNT(d_cnt));

    onehot_encoder #(.W(4), .CW(2), .ERR_DROP(0)) u_cw2 (
        .CLK(clk), .RESET_n(rst_n), .SINK_VALID(sink_valid), .SINK_READY(s_sink_ready),
        .SINK_DATA(sink_data), .SOURCE_VALID(s_src_valid), .SOURCE_READY(src_ready),
        .SOURCE_DATA(s_src_data), .SOURCE_ERR(s_src_err), .ERR_CLR(err_clr), .ERR_COUNT(s_cnt));

    function automatic logic [3:0] m_idx(input logic [15:0] d);
        for (int i = 0; i < 16; i++) begin
            if (d[i]) return 4'(i);
        end
        return 4'd0;
    endfunction

    function automatic err_t m_err(input logic [15:0] d);
        int c;
        c = $countones(d);
        if (c == 0) return ERR_ZERO;
        if (c == 1) return ERR_NONE;
        return ERR_MULTI;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Present one word from a post-edge point and hold it until accepted.
    task automatic send(input logic [15:0] d);
        bit ok;
        int tries;
        tries = 0;
        ok = 1'b0;
        sink_valid = 1'b1;
        sink_data  = d;
        do begin
            @(negedge clk);
            ok = m_sink_ready;
            @(posedge clk);
            #1;
            tries++;
        end while (!ok && tries < 40);
        chk("send_accept", 32'(ok), 32'd1);
        retries += tries - 1;
        sink_valid = 1'b0;
    endtask

    // Scoreboards: push on sink transfer, compare the head on every valid output.
    always @(negedge clk) begin
        if (sink_valid && m_sink_ready)
            q.push_back('{sink_data, m_idx(sink_data), m_err(sink_data), cyc + 1});
        if (sink_valid && d_sink_ready && m_err(sink_data) == ERR_NONE)
            qd.push_back('{sink_data, m_idx(sink_data), ERR_NONE, cyc + 1});
        if (m_src_valid) begin
            chk("main_expected_word", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
                e = q[0];
                chk("main_data", 32'(m_src_data), 32'(e.idx));
                chk("main_err", 32'(m_src_err), 32'(e.err));
                if (src_ready) begin
                    void'(q.pop_front());
                    chk("cw2_data", 32'(s_src_data), 32'(e.idx));
                    chk("cw2_err", 32'(s_src_err), 32'(e.err));
                    if (lat_chk) chk("latency", 32'(cyc + 1 - e.acc_n), 32'd2);
                    if (e.err == ERR_NONE)
                        chk("decoder_loopback", 32'(16'h1 << m_src_data), 32'(e.din));
                end
            end
        end
        if (d_src_valid) begin
            chk("drop_expected_word", 32'(qd.size() > 0), 32'd1);
            if (qd.size() > 0) begin
                ed = qd[0];
                chk("drop_data", 32'(d_src_data), 32'(ed.idx));
                chk("drop_err", 32'(d_src_err), 32'(ERR_NONE));
                if (src_ready) void'(qd.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; sink_valid = 1'b0; sink_data = 16'h0; src_ready = 1'b1; err_clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_src_valid", 32'(m_src_valid), 32'd0);
        chk("rst_src_data", 32'(m_src_data), 32'd0);
        chk("rst_src_err", 32'(m_src_err), 32'(ERR_NONE));
        chk("rst_err_count", 32'(m_cnt), 32'd0);
        chk("rst_sink_ready", 32'(m_sink_ready), 32'd0);
        chk("rst_cw2_sink_ready", 32'(s_sink_ready), 32'd0);
        sync();
        rst_n = 1'b1;

        // Loopback sweep with isolated words and explicit latency checks.
        for (int i = 0; i < 16; i++) begin
            sync();
            send(16'h1 << i);
            @(negedge clk);
            chk("sweep_s1_only", 32'(m_src_valid), 32'd0);
            @(negedge clk);
            chk("sweep_out_valid", 32'(m_src_valid), 32'd1);
            chk("sweep_out_data", 32'(m_src_data), 32'(i));
            chk("sweep_out_err", 32'(m_src_err), 32'(ERR_NONE));
        end

        // Back-to-back streaming: no word may wait.
        sync();
        retries = 0;
        for (int k = 0; k < 16; k++) send(16'h8000 >> k);
        chk("stream_no_stall", 32'(retries), 32'd0);
        repeat (4) sync();

        // Back-pressure for five cycles mid-stream.
        lat_chk = 1'b0;
        fork
            begin
                for (int k = 0; k < 16; k++) send(16'h1 << ((k * 5) % 16));
            end
            begin
                repeat (4) sync();
                src_ready = 1'b0;
                sync();
                @(negedge clk);
                chk("bp_sink_ready", 32'(m_sink_ready), 32'd0);
                chk("bp_src_valid", 32'(m_src_valid), 32'd1);
                repeat (4) sync();
                src_ready = 1'b1;
            end
        join
        repeat (5) sync();
        lat_chk = 1'b1;

        // Error classification and counting.
        err_clr = 1'b1;
        sync();
        err_clr = 1'b0;
        send(16'h0000);
        send(16'h0028);
        repeat (3) sync();
        @(negedge clk);
        chk("err_count_main", 32'(m_cnt), 32'd2);
        chk("err_count_drop", 32'(d_cnt), 32'd2);
        chk("err_count_cw2", 32'(s_cnt), 32'd2);

        // Saturation and clear interactions.
        sync();
        send(16'hFFFF);
        send(16'h0006);
        send(16'h8001);
        @(negedge clk);
        chk("sat_cw2", 32'(s_cnt), 32'd3);
        chk("count_main_5", 32'(m_cnt), 32'd5);
        sync();
        err_clr = 1'b1;
        send(16'h0000);
        err_clr = 1'b0;
        @(negedge clk);
        chk("clr_accept_main", 32'(m_cnt), 32'd1);
        chk("clr_accept_cw2", 32'(s_cnt), 32'd1);
        chk("clr_accept_drop", 32'(d_cnt), 32'd1);
        sync();
        err_clr = 1'b1;
        sync();
        err_clr = 1'b0;
        @(negedge clk);
        chk("clr_alone", 32'(m_cnt), 32'd0);
        repeat (3) sync();

        // Reset with both stages full.
        src_ready = 1'b0;
        send(16'h0010);
        send(16'h0003);
        @(negedge clk);
        chk("full_sink_ready", 32'(m_sink_ready), 32'd0);
        chk("full_err_count", 32'(m_cnt), 32'd1);
        sync();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_sink_ready", 32'(m_sink_ready), 32'd0);
        sync();
        rst_n = 1'b1;
        q.delete();
        qd.delete();
        @(negedge clk);
        chk("post_rst_valid", 32'(m_src_valid), 32'd0);
        chk("post_rst_drop_valid", 32'(d_src_valid), 32'd0);
        chk("post_rst_count", 32'(m_cnt), 32'd0);
        sync();
        src_ready = 1'b1;
        send(16'h0400);
        @(negedge clk);
        chk("post_rst_s1_only", 32'(m_src_valid), 32'd0);
        @(negedge clk);
        chk("post_rst_out_valid", 32'(m_src_valid), 32'd1);
        chk("post_rst_out_data", 32'(m_src_data), 32'd10);

        for (int i = 0; i < 30 && (q.size() > 0 || qd.size() > 0); i++) @(negedge clk);
        chk("drain_main", 32'(q.size()), 32'd0);
        chk("drain_drop", 32'(qd.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
